act_stream: RTL and testbench

ACT_STREAM -- requirements
Module: act_stream

---
 rtl/act_pkg.sv | 8 +
 rtl/act_lane.sv | 51 +++++
 rtl/act_stream.sv | 84 ++++++++
 tb/tb_act_stream.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// act_pkg: shared mode/state types and default widths for the activation stream
package act_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;
    localparam logic [15:0] DEF_CLIP = 16'h0600;
    typedef enum logic [1:0] {PASS = 2'd0, RELU = 2'd1, LEAKY = 2'd2, CLAMP = 2'd3} mode_t;
    typedef enum logic {CFG = 1'b0, DATA = 1'b1} state_t;
endpackage

// File: rtl/act_lane.sv
// act_lane: one activation lane, stage 1 multiplies and captures sign/mode, stage 2 selects and saturates
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter logic [DATA_W-1:0] CLIP = DATA_W'(DEF_CLIP)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] alpha,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] y
);
    localparam logic signed [2*DATA_W-1:0] MAXV = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] MINV = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] YMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] YMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] CLIP_S = CLIP;
    logic signed [2*DATA_W-1:0] p1, sh;
    logic signed [DATA_W-1:0] x1, sat, y_nx;
    mode_t m1;
    logic n1;
    // output selection: arithmetic shift floors toward minus infinity, then clamp to the lane range
    always_comb begin
        sh = p1 >>> FRAC_W;
        sat = sh > MAXV ? YMAX : sh < MINV ? YMIN : sh[DATA_W-1:0];
        y_nx = m1 == PASS ? x1 :
               m1 == RELU ? (n1 ? '0 : x1) :
               m1 == LEAKY ? (n1 ? sat : x1) :
               n1 ? '0 : (x1 > CLIP_S ? CLIP_S : x1);
    end
    // two-stage lane pipeline, both stages frozen together by the shared enable
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            p1 <= '0;
            x1 <= '0;
            m1 <= PASS;
            n1 <= 1'b0;
            y  <= '0;
        end else if (en) begin
            p1 <= $signed(x) * $signed(alpha);
            x1 <= $signed(x);
            m1 <= mode_t'(mode);
            n1 <= x[DATA_W-1];
            y  <= y_nx;
        end
    end
endmodule

// File: rtl/act_stream.sv
// act_stream: AXI-Stream activation unit, one config beat then FRAME_LEN data beats per frame
module act_stream
    import act_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int NUM_CH = 2,
    parameter int FRAME_LEN = 200704,
    parameter logic [DATA_W-1:0] CLIP = DATA_W'(DEF_CLIP)
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_CH*DATA_W-1:0]   S_AXIS_TDATA,
    input  logic                       S_AXIS_TVALID,
    input  logic                       S_AXIS_TLAST,
    output logic                       S_AXIS_TREADY,
    output logic [NUM_CH*DATA_W-1:0]   M_AXIS_TDATA,
    output logic                       M_AXIS_TVALID,
    output logic                       M_AXIS_TLAST,
    output logic [NUM_CH*DATA_W/8-1:0] M_AXIS_TKEEP,
    input  logic                       M_AXIS_TREADY,
    output logic                       err_len
);
    localparam int CW = $clog2(FRAME_LEN) + 1;
    state_t state;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] alpha;
    mode_t mode;
    logic v1, l1, en, hs, dhs, tag_last;
    // handshake and stall control; the config beat bypasses the pipeline so CFG never stalls
    always_comb begin
        en = !M_AXIS_TVALID || M_AXIS_TREADY;
        S_AXIS_TREADY = ARESET ? 1'b0 : state == CFG ? 1'b1 : en;
        hs = S_AXIS_TVALID && S_AXIS_TREADY;
        dhs = hs && state == DATA;
        tag_last = cnt == CW'(FRAME_LEN - 1);
        M_AXIS_TKEEP = '1;
    end
    // frame FSM: capture config, count data beats, flag TLAST disagreements
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= CFG;
            cnt     <= '0;
            alpha   <= '0;
            mode    <= PASS;
            err_len <= 1'b0;
        end else if (hs) begin
            if (state == CFG) begin
                alpha <= S_AXIS_TDATA[DATA_W-1:0];
                mode  <= mode_t'(S_AXIS_TDATA[DATA_W +: 2]);
                state <= DATA;
            end else begin
                cnt     <= tag_last ? '0 : cnt + CW'(1);
                state   <= tag_last ? CFG : DATA;
                err_len <= err_len | (S_AXIS_TLAST != tag_last);
            end
        end
    end
    // valid/last pipeline running in lockstep with the lane registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            v1            <= 1'b0;
            l1            <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (en) begin
            v1            <= dhs;
            l1            <= dhs && tag_last;
            M_AXIS_TVALID <= v1;
            M_AXIS_TLAST  <= l1;
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        act_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CLIP(CLIP)) u_lane (
            .ACLK  (ACLK),
            .ARESET(ARESET),
            .en    (en),
            .x     (S_AXIS_TDATA[i*DATA_W +: DATA_W]),
            .alpha (alpha),
            .mode  (mode),
            .y     (M_AXIS_TDATA[i*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_act_stream.sv
// tb_act_stream: table vectors, random frames with a reference model/scoreboard, TLAST error and reset corners
module tb_act_stream;
    import act_pkg::*;
    localparam int FL = 4;
    logic ACLK, ARESET;
    logic [31:0] S_AXIS_TDATA;
    logic S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic [3:0] M_AXIS_TKEEP;
    logic err_len;
    typedef struct {logic [31:0] d; logic l;} exp_t;
    typedef struct {logic [1:0] mode; logic [15:0] alpha, x0, x1, y0, y1;} vec_t;
    exp_t q[$];
    exp_t e;
    vec_t vt[8];
    int n_chk = 0, n_fail = 0, cyc = 0, rdy_mode = 0, t0;
    logic [15:0] m_alpha;
    logic [1:0] m_mode;
    int m_cnt;
    logic m_err;
    logic prev_v, prev_r, prev_l;
    logic [31:0] prev_d;

    act_stream #(.DATA_W(16), .FRAC_W(8), .NUM_CH(2), .FRAME_LEN(FL), .CLIP(16'h0600)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TREADY(M_AXIS_TREADY), .err_len(err_len)
    );

    initial begin
        ACLK = 0;
        forever #5 ACLK = ~ACLK;
    end
    initial forever begin
        @(posedge ACLK);
        cyc++;
    end
    initial begin
        M_AXIS_TREADY = 1;
        forever begin
            @(posedge ACLK);
            #2;
            M_AXIS_TREADY = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 500000", $time);
        $fatal(1);
    end

    function automatic logic [15:0] act_ref(input logic [15:0] x, input logic [15:0] a, input logic [1:0] m);
        longint xi, ai, s, r;
        xi = longint'($signed(x));
        ai = longint'($signed(a));
        s = (xi * ai) >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        r = m == 0 ? xi : m == 1 ? (xi < 0 ? 0 : xi) : m == 2 ? (xi < 0 ? s : xi) :
            (xi < 0 ? 0 : (xi > 1536 ? 1536 : xi));
        return r[15:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic tl, input string nm);
        logic ok;
        ok = 0;
        S_AXIS_TDATA = d;
        S_AXIS_TVALID = 1;
        S_AXIS_TLAST = tl;
        for (int t = 0; t < 1000 && !ok; t++) begin
            #1;
            ok = S_AXIS_TREADY;
            @(negedge ACLK);
        end
        S_AXIS_TVALID = 0;
        S_AXIS_TLAST = 0;
        chk({nm, "_accept"}, ok, 1);
    endtask

    task automatic send_cfg(input logic [15:0] a, input logic [1:0] m);
        m_alpha = a;
        m_mode = m;
        m_cnt = 0;
        drive({14'($urandom), m, a}, 0, "cfg");
    endtask

    task automatic push_beat(input logic [15:0] x0, input logic [15:0] x1, input logic tl);
        logic lt;
        lt = m_cnt == FL - 1;
        q.push_back('{d: {act_ref(x1, m_alpha, m_mode), act_ref(x0, m_alpha, m_mode)}, l: lt});
        m_err = m_err | (tl != lt);
        m_cnt = lt ? 0 : m_cnt + 1;
    endtask

    task automatic send_data(input logic [15:0] x0, input logic [15:0] x1, input logic tl);
        push_beat(x0, x1, tl);
        drive({x1, x0}, tl, "data");
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && q.size() != 0; t++) @(negedge ACLK);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        prev_v = 0;
        prev_r = 0;
        prev_l = 0;
        prev_d = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) prev_v = 0;
            else begin
                if (prev_v && !prev_r)
                    chk("stall_hold", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {1'b1, prev_l, prev_d});
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    n_chk++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_out: got beat %0h expected none", M_AXIS_TDATA);
                    end else begin
                        e = q.pop_front();
                        if (M_AXIS_TDATA !== e.d || M_AXIS_TLAST !== e.l) begin
                            n_fail++;
                            $display("FAIL out_beat: got %0h/last %0b expected %0h/last %0b", M_AXIS_TDATA, M_AXIS_TLAST, e.d, e.l);
                        end
                    end
                end
                prev_v = M_AXIS_TVALID;
                prev_r = M_AXIS_TREADY;
                prev_l = M_AXIS_TLAST;
                prev_d = M_AXIS_TDATA;
            end
        end
    end

    initial begin
        vt[0] = '{LEAKY, 16'h001A, 16'hFF00, 16'h0200, 16'hFFE6, 16'h0200};
        vt[1] = '{RELU,  16'h0000, 16'hFF00, 16'h0700, 16'h0000, 16'h0700};
        vt[2] = '{PASS,  16'h0000, 16'hFF00, 16'h0700, 16'hFF00, 16'h0700};
        vt[3] = '{CLAMP, 16'h0000, 16'hFF00, 16'h0700, 16'h0000, 16'h0600};
        vt[4] = '{LEAKY, 16'h7FFF, 16'h8000, 16'hFF00, 16'h8000, 16'h8001};
        vt[5] = '{CLAMP, 16'h0000, 16'h0600, 16'h0601, 16'h0600, 16'h0600};
        vt[6] = '{LEAKY, 16'h001A, 16'hFFFF, 16'h8000, 16'hFFFF, 16'hF300};
        vt[7] = '{LEAKY, 16'h0100, 16'h7FFF, 16'hFFFE, 16'h7FFF, 16'hFFFE};
        m_alpha = 0;
        m_mode = 0;
        m_cnt = 0;
        m_err = 0;
        ARESET = 1;
        S_AXIS_TDATA = 0;
        S_AXIS_TVALID = 0;
        S_AXIS_TLAST = 0;
        repeat (3) @(negedge ACLK);
        chk("rst_tready", S_AXIS_TREADY, 0);
        chk("rst_tvalid", M_AXIS_TVALID, 0);
        chk("rst_tlast", M_AXIS_TLAST, 0);
        chk("rst_tdata", M_AXIS_TDATA, 0);
        chk("rst_err", err_len, 0);
        chk("tkeep", M_AXIS_TKEEP, 4'hF);
        ARESET = 0;
        #1 chk("cfg_tready", S_AXIS_TREADY, 1);
        @(negedge ACLK);

        for (int i = 0; i < 8; i++) begin
            send_cfg(vt[i].alpha, vt[i].mode);
            push_beat(vt[i].x0, vt[i].x1, 0);
            S_AXIS_TDATA = {vt[i].x1, vt[i].x0};
            S_AXIS_TVALID = 1;
            #1 chk("vec_tready", S_AXIS_TREADY, 1);
            @(negedge ACLK);
            S_AXIS_TVALID = 0;
            chk("vec_lat1", M_AXIS_TVALID, 0);
            @(negedge ACLK);
            chk("vec_lat2", M_AXIS_TVALID, 1);
            chk($sformatf("vec%0d", i), M_AXIS_TDATA, {vt[i].y1, vt[i].y0});
            t0 = cyc;
            for (int k = 1; k < FL; k++) send_data(vt[i].x0, vt[i].x1, k == FL - 1);
            chk("vec_rate", cyc - t0, FL - 1);
        end
        drain();
        chk("err_clean", err_len, m_err);

        rdy_mode = 1;
        for (int f = 0; f < 6; f++) begin
            send_cfg(16'($urandom), 2'($urandom));
            for (int k = 0; k < FL; k++) begin
                if ($urandom_range(0, 3) == 0) @(negedge ACLK);
                send_data(16'($urandom), 16'($urandom), k == FL - 1);
            end
        end
        drain();
        chk("rnd_err", err_len, m_err);

        rdy_mode = 0;
        send_cfg(16'h0000, RELU);
        send_data(16'h0100, 16'hFF00, 0);
        send_data(16'h8000, 16'h7FFF, 0);
        chk("err_pre", err_len, 0);
        send_data(16'h0001, 16'hFFFF, 1);
        chk("err_set", err_len, 1);
        send_data(16'h0700, 16'hF000, 0);
        drain();
        chk("err_hold", err_len, 1);

        rdy_mode = 2;
        @(negedge ACLK);
        send_cfg(16'h0000, PASS);
        send_data(16'h1111, 16'h2222, 0);
        send_data(16'h3333, 16'h4444, 0);
        chk("pre_rst_valid", M_AXIS_TVALID, 1);
        #1 ARESET = 1;
        #1 chk("rst_tready_mid", S_AXIS_TREADY, 0);
        @(negedge ACLK);
        chk("rst_flush", M_AXIS_TVALID, 0);
        chk("rst_err_clr", err_len, 0);
        q.delete();
        m_cnt = 0;
        m_alpha = 0;
        m_mode = 0;
        m_err = 0;
        rdy_mode = 0;
        #1 ARESET = 0;
        send_cfg(16'h001A, CLAMP);
        for (int k = 0; k < FL; k++) send_data(16'hFF00, 16'h0700, k == FL - 1);
        drain();
        chk("final_err", err_len, m_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
